sdram_bist: RTL
===============

SDRAM_BIST -- requirements
Module: sdram_bist

Interface
REQ-001 Parameter ADDR_W, default 13: width of the address bus to the SDRAM controller user port.
REQ-002 Parameter DATA_W, default 32: width of the controller data bus.
REQ-003 Parameter TIMEOUT, default 10000: watchdog limit in clk cycles per transaction phase.
REQ-004 Port clk  in  1: single clock; every register updates on its rising edge.
REQ-005 Port rst  in  1: asynchronous, active-high reset.
REQ-006 Port start  in  1: one-cycle pulse that begins a test run; ignored while busy=1.
REQ-007 Port mode  in  2: data pattern, latched at start.
REQ-008 Port start_addr / end_addr  in  ADDR_W each: inclusive address range, latched at start.
REQ-009 Port stop_on_err  in  1: abort on first miscompare, latched at start.
REQ-010 Port mem_en, mem_we  out  1 each; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W: request to the controller.
REQ-011 Port mem_rdy, mem_valid  in  1 each; mem_rdata  in  DATA_W: controller status and read data.
REQ-012 Port busy, done, pass, timeout, range_err  out  1 each: run status.
REQ-013 Port err_cnt  out  16; err_addr  out  ADDR_W; err_exp, err_got  out  DATA_W: first-failure capture and error count.

Function
REQ-014 FSM states: IDLE, WR_WAIT, WR_ISSUE, WR_BUSY, WR_DONE, RD_WAIT, RD_ISSUE, RD_DATA, FINISH.
REQ-015 IDLE + start: latch inputs, clear err_cnt, done, pass, timeout, range_err; set cur_addr=start_addr, busy=1; go to WR_WAIT.
REQ-016 If end_addr < start_addr at start: range_err=1, done=1, pass=0, busy=0; no memory request.
REQ-017 WR_WAIT: wait for mem_rdy=1, then WR_ISSUE.
REQ-018 WR_ISSUE: mem_en=1 and mem_we=1 for exactly one cycle, with mem_addr=cur_addr and mem_wdata=pattern(cur_addr); then WR_BUSY.
REQ-019 WR_BUSY: wait for mem_rdy=0; WR_DONE: wait for mem_rdy=1.
REQ-020 After WR_DONE: if cur_addr==end_addr, set cur_addr=start_addr and go to RD_WAIT; otherwise increment cur_addr and go to WR_WAIT.
REQ-021 RD_WAIT: wait for mem_rdy=1; RD_ISSUE: one-cycle mem_en=1, mem_we=0, mem_addr=cur_addr; then RD_DATA.
REQ-022 RD_DATA: on the first cycle with mem_valid=1, sample mem_rdata and compare it with pattern(cur_addr) in that cycle.
REQ-023 On miscompare: increment err_cnt, saturating at 16'hFFFF. On the first miscompare only, capture err_addr, err_exp, err_got.
REQ-024 Miscompare with stop_on_err=1: go to FINISH immediately.
REQ-025 After RD_DATA: if cur_addr==end_addr go to FINISH; otherwise increment and go to RD_WAIT.
REQ-026 Address-range termination uses equality only. end_addr = 2^ADDR_W-1 terminates without wrap; start_addr==end_addr runs exactly one write and one read.
REQ-027 Pattern by mode:
  0 = all ones.
  1 = 0x55.. when addr[0]=0, 0xAA.. when addr[0]=1.
  2 = address zero-extended to DATA_W.
  3 = 1 << (addr mod DATA_W).
REQ-028 Watchdog: a counter clears on entry to each WAIT/BUSY/DONE/DATA state and increments every cycle while in it.
REQ-029 Watchdog reaching TIMEOUT: timeout=1, then FINISH.
REQ-030 FINISH, one cycle: busy=0, done=1, pass=(err_cnt==0 && !timeout); then IDLE.
REQ-031 done, pass, timeout, err_* hold their values until the next accepted start.
REQ-032 mem_en is never high in two consecutive cycles and never high outside the ISSUE states.
REQ-033 mem_rdy and mem_valid are ignored in IDLE and FINISH. A mem_valid outside RD_DATA is neither counted nor compared.

Reset
REQ-034 rst=1 asynchronously forces:
  state=IDLE;
  mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0;
  busy, done, pass, timeout, range_err=0;
  err_cnt, err_addr, err_exp, err_got=0;
  watchdog=0.
REQ-035 rst asserted mid-run aborts the run with no further mem_en. After release the block sits in IDLE until a new start.

Verification
REQ-036 Against sdram_cnt + mt48lc2m32b2: mode=1, range 0..3 -> 4 writes then 4 reads; done=1, pass=1, err_cnt=0.
REQ-037 Responder corrupts the read of address 2 to 0 with mode=2 and stop_on_err=0 -> err_cnt=1, err_addr=2, err_exp=2, err_got=0, pass=0; all 4 reads are issued.
REQ-038 Same corruption with stop_on_err=1 and range 0..7 -> FINISH after the read of address 2; 8 writes and 3 reads are issued.
REQ-039 Responder holds mem_rdy=0 after the first write, with TIMEOUT=100 -> timeout=1, done=1, pass=0 within 102 cycles.
REQ-040 start_addr=5, end_addr=4 -> range_err=1, done=1, no mem_en. Separately, start_addr=end_addr=8191 -> exactly 1 write and 1 read, pass=1.
REQ-041 rst pulsed during RD_DATA -> all outputs return to 0 immediately. A following start with range 0..0 completes with pass=1.

Source files
------------

// File: rtl/sdram_bist_if.sv
// rtl/sdram_bist_if.sv - request/response bus between the BIST engine and the SDRAM controller user port
interface sdram_bist_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rdy;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdy, mem_valid, mem_rdata
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdy, mem_valid, mem_rdata
  );
endinterface

// File: rtl/sdram_bist.sv
// rtl/sdram_bist.sv - write-then-read-back pattern test engine for an SDRAM controller user port
module sdram_bist #(
  parameter int ADDR_W  = 13,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              stop_on_err,
  sdram_bist_if.master      mem,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              range_err,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_got
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, WR_WAIT, WR_ISSUE, WR_BUSY, WR_DONE, RD_WAIT, RD_ISSUE, RD_DATA, FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  logic [1:0]        mode_q, mode_d;
  logic              stop_q, stop_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic              range_err_q, range_err_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [DATA_W-1:0] err_exp_q, err_exp_d;
  logic [DATA_W-1:0] err_got_q, err_got_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic [DATA_W-1:0] exp_data;
  logic              hold;

  // Expected data for an address under the selected pattern mode
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] addr, input logic [1:0] m);
    logic [DATA_W-1:0] p;
    logic [31:0]       bit_pos;
    bit_pos = 32'(addr) % 32'(DATA_W);
    p = '0;
    for (int i = 0; i < DATA_W; i++) begin
      case (m)
        2'd0:    p[i] = 1'b1;
        2'd1:    p[i] = addr[0] ^ ~i[0];
        2'd2:    p[i] = 1'b0;
        default: p[i] = (bit_pos == 32'(i));
      endcase
    end
    if (m == 2'd2) p = DATA_W'(addr);
    return p;
  endfunction

  assign exp_data = pattern(cur_addr_q, mode_q);

  // Requests are decoded from the state so mem_en can only be high for the single ISSUE cycle
  assign mem.mem_en    = (state_q == WR_ISSUE) || (state_q == RD_ISSUE);
  assign mem.mem_we    = (state_q == WR_ISSUE);
  assign mem.mem_addr  = mem.mem_en ? cur_addr_q : '0;
  assign mem.mem_wdata = mem.mem_we ? exp_data : '0;

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign range_err = range_err_q;
  assign err_cnt   = err_cnt_q;
  assign err_addr  = err_addr_q;
  assign err_exp   = err_exp_q;
  assign err_got   = err_got_q;

  // Next-state, run bookkeeping and watchdog
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    start_addr_d = start_addr_q;
    end_addr_d   = end_addr_q;
    mode_d       = mode_q;
    stop_d       = stop_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    range_err_d  = range_err_q;
    err_cnt_d    = err_cnt_q;
    err_addr_d   = err_addr_q;
    err_exp_d    = err_exp_q;
    err_got_d    = err_got_q;
    wdog_d       = '0;
    hold         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d       = mode;
          start_addr_d = start_addr;
          end_addr_d   = end_addr;
          stop_d       = stop_on_err;
          err_cnt_d    = '0;
          err_addr_d   = '0;
          err_exp_d    = '0;
          err_got_d    = '0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          timeout_d    = 1'b0;
          range_err_d  = 1'b0;
          if (end_addr < start_addr) begin
            range_err_d = 1'b1;
            done_d      = 1'b1;
            busy_d      = 1'b0;
          end else begin
            cur_addr_d = start_addr;
            busy_d     = 1'b1;
            state_d    = WR_WAIT;
          end
        end
      end
      WR_WAIT: begin
        if (mem.mem_rdy) state_d = WR_ISSUE;
        else             hold = 1'b1;
      end
      WR_ISSUE: state_d = WR_BUSY;
      WR_BUSY: begin
        if (!mem.mem_rdy) state_d = WR_DONE;
        else              hold = 1'b1;
      end
      WR_DONE: begin
        if (mem.mem_rdy) begin
          if (cur_addr_q == end_addr_q) begin
            cur_addr_d = start_addr_q;
            state_d    = RD_WAIT;
          end else begin
            cur_addr_d = cur_addr_q + 1'b1;
            state_d    = WR_WAIT;
          end
        end else begin
          hold = 1'b1;
        end
      end
      RD_WAIT: begin
        if (mem.mem_rdy) state_d = RD_ISSUE;
        else             hold = 1'b1;
      end
      RD_ISSUE: state_d = RD_DATA;
      RD_DATA: begin
        if (mem.mem_valid) begin
          if (mem.mem_rdata != exp_data) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (err_cnt_q == 16'd0) begin
              err_addr_d = cur_addr_q;
              err_exp_d  = exp_data;
              err_got_d  = mem.mem_rdata;
            end
          end
          if ((mem.mem_rdata != exp_data) && stop_q) begin
            state_d = FINISH;
          end else if (cur_addr_q == end_addr_q) begin
            state_d = FINISH;
          end else begin
            cur_addr_d = cur_addr_q + 1'b1;
            state_d    = RD_WAIT;
          end
        end else begin
          hold = 1'b1;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_cnt_q == 16'd0) && !timeout_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Still waiting on the controller: count, or give up once the limit is reached
    if (hold) begin
      if (wdog_q >= WD_LAST) begin
        timeout_d = 1'b1;
        state_d   = FINISH;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
  end

  // State and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      start_addr_q <= '0;
      end_addr_q   <= '0;
      mode_q       <= '0;
      stop_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      range_err_q  <= 1'b0;
      err_cnt_q    <= '0;
      err_addr_q   <= '0;
      err_exp_q    <= '0;
      err_got_q    <= '0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      start_addr_q <= start_addr_d;
      end_addr_q   <= end_addr_d;
      mode_q       <= mode_d;
      stop_q       <= stop_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      range_err_q  <= range_err_d;
      err_cnt_q    <= err_cnt_d;
      err_addr_q   <= err_addr_d;
      err_exp_q    <= err_exp_d;
      err_got_q    <= err_got_d;
      wdog_q       <= wdog_d;
    end
  end

endmodule
